// File: rtl/dac_wave_pkg.sv
// Shared types and constants for the DAC waveform player.
package dac_wave_pkg;

    localparam int unsigned SAMPLE_W         = 16;
    localparam int unsigned SAMPLES_PER_WORD = 16;
    localparam int unsigned WORD_W           = SAMPLE_W * SAMPLES_PER_WORD;

    typedef logic signed [SAMPLE_W-1:0] sample_t;
    typedef logic [WORD_W-1:0]          dac_word_t;

    typedef enum logic [1:0] {
        StIdle,
        StPlay,
        StDrain
    } state_t;

    // Gain is signed Q1.14: 0x4000 is unity.
    localparam int unsigned GAIN_W    = 16;
    localparam int unsigned GAIN_FRAC = 14;
    typedef logic signed [GAIN_W-1:0] gain_t;
    localparam gain_t GAIN_UNITY = 16'sh4000;

    localparam int SAT_MAX = (1 << (SAMPLE_W - 1)) - 1;
    localparam int SAT_MIN = -(1 << (SAMPLE_W - 1));

    function automatic sample_t apply_gain(input sample_t s, input gain_t g);
        int prod;
        prod = (int'(s) * int'(g)) >>> GAIN_FRAC;
        if (prod > SAT_MAX) begin
            return sample_t'(SAT_MAX);
        end else if (prod < SAT_MIN) begin
            return sample_t'(SAT_MIN);
        end else begin
            return sample_t'(prod);
        end
    endfunction

endpackage

// File: rtl/dac_wave_ram.sv
// Simple dual-port waveform RAM with registered read; a same-address read returns old data.
module dac_wave_ram
    import dac_wave_pkg::*;
#(
    parameter int unsigned WIDTH  = WORD_W,
    parameter int unsigned DEPTH  = 256,
    parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/dac_wave_player.sv
// Streams a RAM-held waveform to the DAC shifter, one word per clock, with pass looping.
// Define DAC_WAVE_GAIN_EN to add a Q1.14 gain stage (one extra cycle of latency).
module dac_wave_player #(
    parameter int unsigned SAMPLE_W         = 16,
    parameter int unsigned SAMPLES_PER_WORD = 16,
    parameter int unsigned DEPTH            = 256,
    parameter int unsigned ADDR_W           = $clog2(DEPTH)
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 wr_en,
    input  logic [ADDR_W-1:0]                    wr_addr,
    input  logic [SAMPLE_W*SAMPLES_PER_WORD-1:0] wr_data,
    input  logic [ADDR_W:0]                      wave_len,
    input  logic [7:0]                           loop_cnt,
    input  logic                                 start,
    input  logic                                 abort,
`ifdef DAC_WAVE_GAIN_EN
    input  logic signed [15:0]                   gain,
`endif
    output logic                                 busy,
    output logic                                 done,
    output logic                                 dac_valid,
    output logic [SAMPLE_W*SAMPLES_PER_WORD-1:0] dac_word_out
);
    import dac_wave_pkg::*;

    localparam int unsigned    WORD_BITS = SAMPLE_W * SAMPLES_PER_WORD;
    localparam logic [ADDR_W:0] DEPTH_L  = DEPTH[ADDR_W:0];

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
    logic [7:0]          pass_q, pass_d;
    logic [ADDR_W:0]     len_q, len_d;
    logic [7:0]          loops_q, loops_d;
    logic                valid_q, valid_d;
    logic                done_q, done_d;
    logic                rd_en;
    logic [WORD_BITS-1:0] ram_data;
    logic [ADDR_W:0]     len_m1;
    logic                at_wrap;
    logic                last_pass;

    assign len_m1    = len_q - 1'b1;
    assign at_wrap   = ({1'b0, rd_addr_q} == len_m1);
    // loops_q == 0 means play forever, so no pass is ever the last one.
    assign last_pass = (loops_q != 8'd0) && (pass_q == loops_q - 8'd1);

`ifdef DAC_WAVE_GAIN_EN
    gain_t gain_q, gain_d;
`endif

    always_comb begin
        state_d   = state_q;
        rd_addr_d = rd_addr_q;
        pass_d    = pass_q;
        len_d     = len_q;
        loops_d   = loops_q;
        valid_d   = 1'b0;
        done_d    = 1'b0;
        rd_en     = 1'b0;
`ifdef DAC_WAVE_GAIN_EN
        gain_d    = gain_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (start && !abort) begin
                    if (wave_len == '0) begin
                        done_d = 1'b1;
                    end else begin
                        len_d     = (wave_len > DEPTH_L) ? DEPTH_L : wave_len;
                        loops_d   = loop_cnt;
                        rd_addr_d = '0;
                        pass_d    = '0;
                        state_d   = StPlay;
`ifdef DAC_WAVE_GAIN_EN
                        gain_d    = gain;
`endif
                    end
                end
            end
            StPlay: begin
                if (abort) begin
                    done_d  = 1'b1;
                    state_d = StIdle;
                end else begin
                    rd_en   = 1'b1;
                    valid_d = 1'b1;
                    if (at_wrap) begin
                        rd_addr_d = '0;
                        if (last_pass) begin
                            state_d = StDrain;
                        end else begin
                            pass_d = pass_q + 8'd1;
                        end
                    end else begin
                        rd_addr_d = rd_addr_q + 1'b1;
                    end
                end
            end
            StDrain: begin
                // Final word is on the output this cycle; completion follows.
                done_d  = 1'b1;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            rd_addr_q <= '0;
            pass_q    <= '0;
            len_q     <= '0;
            loops_q   <= '0;
            valid_q   <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            rd_addr_q <= rd_addr_d;
            pass_q    <= pass_d;
            len_q     <= len_d;
            loops_q   <= loops_d;
            valid_q   <= valid_d;
            done_q    <= done_d;
        end
    end

    dac_wave_ram #(
        .WIDTH  (WORD_BITS),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_en   (rd_en),
        .rd_addr (rd_addr_q),
        .rd_data (ram_data)
    );

    assign busy = (state_q != StIdle);

`ifdef DAC_WAVE_GAIN_EN
    logic [WORD_BITS-1:0] gained;
    logic [WORD_BITS-1:0] word_q;
    logic                 valid2_q;
    logic                 done2_q;

    always_comb begin
        gained = '0;
        for (int i = 0; i < int'(SAMPLES_PER_WORD); i++) begin
            gained[i*SAMPLE_W +: SAMPLE_W] =
                apply_gain(sample_t'(ram_data[i*SAMPLE_W +: SAMPLE_W]), gain_q);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gain_q   <= GAIN_UNITY;
            word_q   <= '0;
            valid2_q <= 1'b0;
            done2_q  <= 1'b0;
        end else begin
            gain_q   <= gain_d;
            word_q   <= valid_q ? gained : '0;
            valid2_q <= valid_q;
            done2_q  <= done_q;
        end
    end

    assign dac_valid    = valid2_q;
    assign done         = done2_q;
    assign dac_word_out = word_q;
`else
    assign dac_valid    = valid_q;
    assign done         = done_q;
    // Silence outside playback: the RAM output register is not reset.
    assign dac_word_out = valid_q ? ram_data : '0;
`endif

endmodule

// File: tb/tb_dac_wave_player.sv
// Scoreboard bench for dac_wave_player: stimulus pushes expected words, a monitor pops and compares.
module tb_dac_wave_player;
    import dac_wave_pkg::*;

    localparam int unsigned DEPTH  = 256;
    localparam int unsigned ADDR_W = 8;
`ifdef DAC_WAVE_GAIN_EN
    localparam int EXTRA = 1;
`else
    localparam int EXTRA = 0;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              wr_en = 1'b0;
    logic [ADDR_W-1:0] wr_addr = '0;
    dac_word_t         wr_data = '0;
    logic [ADDR_W:0]   wave_len = '0;
    logic [7:0]        loop_cnt = '0;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic              busy;
    logic              done;
    logic              dac_valid;
    dac_word_t         dac_word_out;
`ifdef DAC_WAVE_GAIN_EN
    logic signed [15:0] gain = 16'sh4000;
`endif

    dac_wave_player #(
        .SAMPLE_W         (16),
        .SAMPLES_PER_WORD (16),
        .DEPTH            (DEPTH),
        .ADDR_W           (ADDR_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .wave_len     (wave_len),
        .loop_cnt     (loop_cnt),
        .start        (start),
        .abort        (abort),
`ifdef DAC_WAVE_GAIN_EN
        .gain         (gain),
`endif
        .busy         (busy),
        .done         (done),
        .dac_valid    (dac_valid),
        .dac_word_out (dac_word_out)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int        n_cmp = 0;
    int        n_err = 0;
    dac_word_t exp_q[$];
    dac_word_t model[8];
    int        first_v = -1;
    int        last_v = -1;
    int        nvalid = 0;
    int        ndone = 0;

    task automatic check_w(input string nm, input dac_word_t act, input dac_word_t req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h want %h", nm, act, req);
        end
    endtask

    task automatic check_i(input string nm, input int act, input int req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0d want %0d", nm, act, req);
        end
    endtask

    // Monitor: every valid word must match the head of the scoreboard; idle output must be zero.
    always @(negedge clk) begin
        if (done === 1'b1) ndone++;
        if (dac_valid === 1'b1) begin
            if (first_v < 0) first_v = cyc;
            last_v = cyc;
            nvalid++;
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_word: got %h want no word", dac_word_out);
            end else begin
                check_w("word", dac_word_out, exp_q.pop_front());
            end
        end else begin
            check_w("idle_zero", dac_word_out, '0);
        end
    end

    function automatic dac_word_t pat(input int i);
        dac_word_t w;
        for (int k = 0; k < 16; k++) w[k*16 +: 16] = 16'((i + 1) * 256 + k * 7 + 3);
        return w;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_stats();
        first_v = -1;
        last_v  = -1;
        nvalid  = 0;
        ndone   = 0;
    endtask

    task automatic ram_wr(input int a, input dac_word_t d);
        wr_en   = 1'b1;
        wr_addr = ADDR_W'(a);
        wr_data = d;
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int at);
        at = -1;
        for (int i = 0; i < budget; i++) begin
            if (done === 1'b1) begin
                at = cyc;
                break;
            end
            tick();
        end
        if (at < 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL done_timeout: got no done within %0d cycles want done", budget);
        end
    endtask

    // One complete playback; optional second start pulse while busy must be ignored.
    task automatic run(input int len, input int loops, input bit poke);
        int t0;
        int d;
        tick();
        clr_stats();
        for (int p = 0; p < loops; p++)
            for (int a = 0; a < len; a++) exp_q.push_back(model[a]);
        wave_len = (ADDR_W + 1)'(len);
        loop_cnt = 8'(loops);
        start    = 1'b1;
        t0       = cyc;
        tick();
        start = 1'b0;
        if (poke) begin
            tick();
            tick();
            wave_len = 9'd1;
            loop_cnt = 8'd1;
            start    = 1'b1;
            tick();
            start = 1'b0;
        end
        wait_done(len * loops + 10 + EXTRA, d);
        check_i("first_valid_cycle", first_v, t0 + 2 + EXTRA);
        check_i("valid_count", nvalid, len * loops);
        check_i("contiguous", last_v - first_v + 1, nvalid);
        check_i("done_cycle", d, t0 + 2 + EXTRA + len * loops);
        repeat (3) tick();
        check_i("single_done", ndone, 1);
        check_i("queue_drained", exp_q.size(), 0);
        check_i("busy_after", int'(busy), 0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1);
    end

    initial begin
        int t0;
        for (int i = 0; i < 8; i++) model[i] = pat(i);

        repeat (3) tick();
        check_i("rst_busy", int'(busy), 0);
        check_i("rst_done", int'(done), 0);
        check_i("rst_valid", int'(dac_valid), 0);
        check_w("rst_word", dac_word_out, '0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 8; i++) ram_wr(i, model[i]);

        run(4, 1, 1'b0);
        run(3, 3, 1'b1);

        // Infinite mode, aborted after the seventh word.
        tick();
        clr_stats();
        for (int i = 0; i < 7; i++) exp_q.push_back(model[i % 2]);
        wave_len = 9'd2;
        loop_cnt = 8'd0;
        start    = 1'b1;
        t0       = cyc;
        tick();
        start = 1'b0;
        repeat (7) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        repeat (EXTRA) tick();
        check_i("abort_cycle", cyc, t0 + 9 + EXTRA);
        check_i("abort_valid", int'(dac_valid), 0);
        check_w("abort_word", dac_word_out, '0);
        check_i("abort_done", int'(done), 1);
        check_i("abort_busy", int'(busy), 0);
        check_i("abort_nvalid", nvalid, 7);
        check_i("abort_queue", exp_q.size(), 0);

        // start and abort together in idle: nothing happens.
        tick();
        clr_stats();
        wave_len = 9'd2;
        loop_cnt = 8'd1;
        start    = 1'b1;
        abort    = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        repeat (4) tick();
        check_i("startabort_busy", int'(busy), 0);
        check_i("startabort_done", ndone, 0);
        check_i("startabort_valid", nvalid, 0);

        // Zero-length start: done only.
        clr_stats();
        wave_len = 9'd0;
        loop_cnt = 8'd1;
        start    = 1'b1;
        tick();
        start = 1'b0;
        repeat (EXTRA) tick();
        check_i("zlen_done", int'(done), 1);
        check_i("zlen_busy", int'(busy), 0);
        repeat (4) tick();
        check_i("zlen_ndone", ndone, 1);
        check_i("zlen_nvalid", nvalid, 0);

        // Reset mid-playback, then replay from word 0 with RAM retained.
        clr_stats();
        for (int i = 0; i < 5; i++) exp_q.push_back(model[i % 4]);
        wave_len = 9'd4;
        loop_cnt = 8'd0;
        start    = 1'b1;
        tick();
        start = 1'b0;
        repeat (6 + EXTRA) tick();
        rst = 1'b1;
        #1;
        check_i("midrst_valid", int'(dac_valid), 0);
        check_w("midrst_word", dac_word_out, '0);
        check_i("midrst_busy", int'(busy), 0);
        check_i("midrst_done", int'(done), 0);
        tick();
        check_i("midrst_nvalid", nvalid, 5);
        check_i("midrst_queue", exp_q.size(), 0);
        rst = 1'b0;
        tick();
        run(4, 2, 1'b0);

`ifdef DAC_WAVE_GAIN_EN
        begin
            dac_word_t raw;
            dac_word_t e;
            raw = '0;
            raw[15:0]  = 16'h4000;
            raw[31:16] = 16'h7FFF;
            raw[47:32] = 16'h8000;
            ram_wr(0, raw);
            e = '0;
            e[15:0]  = 16'h2000;
            e[31:16] = 16'h3FFF;
            e[47:32] = 16'hC000;
            model[0] = e;
            gain = 16'sh2000;
            run(1, 1, 1'b0);
            e = '0;
            e[15:0]  = 16'h7FFF;
            e[31:16] = 16'h7FFF;
            e[47:32] = 16'h8000;
            model[0] = e;
            gain = 16'sh7FFF;
            run(1, 1, 1'b0);
        end
`endif

        repeat (2) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/dac_wave_player.md
Name: dac_wave_player

Overview:
- Upstream stage of the DAC single-sample shifter.
- Holds a programmable waveform in an on-chip word RAM and plays it back one 256-bit DAC word (16 × 16-bit samples) per clock.
- Output drives the shifter's word input directly.
- Host loads the RAM, sets length and loop count, then triggers; the block streams the words, repeats them as programmed, then returns to zero output.

Parameters:
- SAMPLE_W, 16, bits per DAC sample (signed two's complement).
- SAMPLES_PER_WORD, 16, samples per DAC word.
- DEPTH, 256, waveform RAM depth in words (power of two).
- ADDR_W, $clog2(DEPTH), RAM address width.

Ports:
- clk  in  1  single clock.
- rst  in  1  asynchronous active-high reset.
- wr_en  in  1  host RAM write strobe.
- wr_addr  in  ADDR_W  host RAM write address.
- wr_data  in  SAMPLE_W*SAMPLES_PER_WORD  host RAM write word.
- wave_len  in  ADDR_W+1  words per pass (1..DEPTH); sampled on start.
- loop_cnt  in  8  passes to play; 0 = repeat until abort; sampled on start.
- start  in  1  trigger pulse.
- abort  in  1  stop playback.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle completion pulse.
- dac_valid  out  1  high while dac_word_out carries waveform data.
- dac_word_out  out  SAMPLE_W*SAMPLES_PER_WORD  word to the shifter.

Behaviour:
- Reset: busy=0, done=0, dac_valid=0, dac_word_out=0, FSM=IDLE, counters=0. RAM contents are not cleared.
- Reset asserted mid-playback: outputs go to reset values immediately (asynchronously).
- RAM: simple dual port.
  - Write port: always usable, including during playback.
  - Read: registered, 1-cycle latency.
  - Same-address write and read in the same cycle: the read returns the old data.
- FSM states: IDLE, PLAY, DRAIN.
  - IDLE: start=1 with wave_len!=0 → latch wave_len and loop_cnt, rd_addr=0 → PLAY.
  - IDLE: start=1 with wave_len==0 → done=1 next cycle, stay IDLE, dac_valid never asserted.
  - PLAY: issue one read per cycle. rd_addr increments and wraps to 0 after wave_len-1. The pass counter increments on each wrap. After the last read of the last pass → DRAIN.
  - DRAIN: wait one cycle for the final RAM output to be registered, then assert done for 1 cycle → IDLE.
- Latency:
  - start high in cycle N → first word valid at dac_word_out in cycle N+2.
  - Words are contiguous with no bubbles, including across pass boundaries.
  - dac_valid is high for exactly wave_len*loop_cnt cycles.
  - done is high in the first cycle after the last valid word.
- Infinite mode (loop_cnt=0): plays indefinitely; only abort ends it.
- abort:
  - In PLAY or DRAIN: next cycle dac_valid=0, dac_word_out=0, done=1 → IDLE.
  - In IDLE: no effect.
  - abort has priority over a simultaneous start.
- start while busy: ignored.
- When dac_valid=0, dac_word_out is forced to zero. The shifter therefore sees silence outside playback.
- wave_len > DEPTH: clamped to DEPTH.

Optional Feature:
- Macro: DAC_WAVE_GAIN_EN.
- Enabled:
  - Adds input port gain (16 bits, signed Q1.14), sampled on start.
  - Each sample is computed as sample*gain >>> 14, saturated to the SAMPLE_W signed range.
  - Adds one pipeline register: first word at N+3. dac_valid and done are each delayed by 1 cycle.
- Disabled: no gain port; samples pass unchanged; latency as above.

Decomposition:
- Package dac_wave_pkg:
  - SAMPLE_W, SAMPLES_PER_WORD, WORD_W=256.
  - typedef sample_t (signed [SAMPLE_W-1:0]).
  - typedef dac_word_t ([WORD_W-1:0]).
  - FSM state enum.
  - Gain Q-format constants.
- Sub-module dac_wave_ram: simple dual-port registered-read RAM (DEPTH × WORD_W).
- The FSM, counters and gain logic stay in the top module.

Test Plan:
- Load words 0..3 with distinct patterns; wave_len=4, loop_cnt=1, start at cycle 10 → words 0,1,2,3 valid cycles 12–15; done at 16; output 0 afterwards.
- wave_len=3, loop_cnt=3 → 9 contiguous valid cycles in order 0,1,2,0,1,2,0,1,2 with no gaps; single done pulse.
- loop_cnt=0, wave_len=2; assert abort after 7 valid words → dac_valid and dac_word_out drop to 0 next cycle; done=1; busy=0. Also check start+abort in the same IDLE cycle → stays IDLE.
- wave_len=0 start → done one cycle later, dac_valid never high. Start pulse while busy → stream unchanged.
- Assert rst mid-playback → outputs 0 immediately. After release, replay is correct from word 0 with RAM contents retained.
- With DAC_WAVE_GAIN_EN:
  - gain=0x2000 (0.5) on sample 0x4000 → 0x2000.
  - gain=0x7FFF on 0x7FFF → saturates to 0x7FFF.
  - gain=0x7FFF on 0x8000 → 0x8000.
  - First word appears at N+3.
